serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial two's-complement subtractor: computes DIFF = A - B - BIN.
//  Built around a single full-subtractor cell and a borrow flip-flop.
//  Processes one bit per clock, LSB first. Counterpart of the full-adder datapath.
//  Sits beside the adder cells as the arithmetic-unit subtract path; start/done handshake.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      synchronous, active-high reset
//  start       in   1      1-cycle request; accepted in IDLE or DONE only
//  a           in   WIDTH  minuend, sampled on accepted start
//  b           in   WIDTH  subtrahend, sampled on accepted start
//  bin         in   1      borrow-in, sampled on accepted start
//  busy        out  1      high while in RUN
//  diff_bit    out  1      current serial difference bit (LSB first)
//  diff_valid  out  1      diff_bit valid this cycle (RUN only)
//  done        out  1      1-cycle pulse: diff/bout final
//  diff        out  WIDTH  parallel result, held until next accepted start
//  bout        out  1      final borrow-out (1 => unsigned A < B+BIN), held
//  ovf         out  1      signed overflow (only with SERSUB_OVF_EN)
// BEHAVIOUR
//  - Reset (rst=1 at clk edge):
//    - state=IDLE; all outputs 0; shift regs, borrow FF, bit counter cleared.
//    - Applies mid-operation; the partial result is discarded.
//  - FSM: IDLE -> RUN on start; RUN -> DONE after WIDTH bit-cycles; DONE -> IDLE.
//    - DONE -> RUN directly if start=1 in DONE (back-to-back accepted).
//  - Accept edge:
//    - Load a->sa, b->sb, bin->br; cnt=0.
//    - Clear diff, bout, ovf.
//    - Enter RUN.
//  - start in RUN is ignored: no reload, no effect on the operation in flight.
//  - RUN, each cycle k = 0..WIDTH-1, with x=sa[0], y=sb[0]:
//    - d = x^y^br; nb = (~x&y) | (~(x^y)&br).
//    - diff_bit=d, diff_valid=1 (combinational from regs).
//    - At the edge: br<=nb; sa,sb shift right; d shifts into diff MSB; cnt++.
//  - After bit WIDTH-1 is processed: state=DONE for exactly 1 cycle.
//    - done=1; diff holds the full result; bout=br; busy=0; diff_valid=0.
//  - Latency: start accepted at edge 0; done high in the cycle after edge WIDTH.
//  - Throughput: one op per WIDTH+1 cycles with back-to-back starts.
//  - Arithmetic is mod 2^WIDTH; bout is the unsigned borrow from the MSB stage.
//  - cnt width = $clog2(WIDTH+1); no wrap inside an operation.
// CONFIGURATION
//  - SERSUB_OVF_EN defined:
//    - ovf = (a[MSB] ^ b[MSB]) & (a[MSB] ^ diff[MSB]), computed from the sampled operands.
//    - Valid from the DONE cycle; held with diff; cleared on reset and on accept.
//  - SERSUB_OVF_EN undefined:
//    - No ovf logic and no MSB capture registers.
//    - ovf port tied to 0.
// TESTING (WIDTH=8)
//  1. a=8'h5A b=8'h3C bin=0 start -> 8 diff_valid cycles; done at cycle 9; diff=8'h1E, bout=0.
//     - diff_bit sequence: 0,1,1,1,1,0,0,0.
//  2. a=8'h00 b=8'h01 bin=0 -> diff=8'hFF, bout=1; ovf=0 with SERSUB_OVF_EN.
//  3. a=8'h10 b=8'h0F bin=1 -> diff=8'h00, bout=0.
//     - a=8'h00 b=8'h00 bin=1 -> diff=8'hFF, bout=1.
//  4. SERSUB_OVF_EN: a=8'h80 b=8'h01 -> diff=8'h7F, ovf=1.
//     - a=8'h7F b=8'hFF -> diff=8'h80, ovf=1.
//     - Macro undefined: ovf stays 0.
//  5. start pulse with new operands at RUN cycle 3 -> ignored; result equals the first operation.
//     - start held during DONE -> new op begins; busy high the next cycle; no IDLE cycle.
//  6. rst=1 at RUN cycle 4 -> next cycle busy=done=diff_valid=0, diff=0, bout=0.
//     - A fresh start then yields the correct result.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (DIFF = A - B - BIN), LSB first, one bit per clock.
// Optional signed-overflow flag enabled by defining SERSUB_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             diff_bit,
    output logic             diff_valid,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;

    logic x_c;
    logic y_c;
    logic d_c;
    logic nb_c;
    logic accept_c;
    logic last_c;

    // Single full-subtractor cell operating on the current LSBs.
    assign x_c      = sa_q[0];
    assign y_c      = sb_q[0];
    assign d_c      = x_c ^ y_c ^ br_q;
    assign nb_c     = (~x_c & y_c) | (~(x_c ^ y_c) & br_q);
    assign accept_c = start && (state_q != RUN);
    assign last_c   = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (accept_c) begin
                        state_q <= RUN;
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        diff_q  <= '0;
                        bout_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    br_q   <= nb_c;
                    sa_q   <= {1'b0, sa_q[WIDTH-1:1]};
                    sb_q   <= {1'b0, sb_q[WIDTH-1:1]};
                    diff_q <= {d_c, diff_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_c) begin
                        state_q <= DONE;
                        bout_q  <= nb_c;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    logic am_q;
    logic bm_q;
    logic ovf_q;

    // Operand sign bits are captured at accept since sa/sb are shifted away.
    always_ff @(posedge clk) begin
        if (rst) begin
            am_q  <= 1'b0;
            bm_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept_c) begin
            am_q  <= a[WIDTH-1];
            bm_q  <= b[WIDTH-1];
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_c) begin
            ovf_q <= (am_q ^ bm_q) & (am_q ^ d_c);
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign diff_valid = busy;
    assign diff_bit   = busy & d_c;
    assign diff       = diff_q;
    assign bout       = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); define SERSUB_OVF_EN to check ovf.
module tb_serial_subtractor;

    localparam int unsigned W = 8;
`ifdef SERSUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         diff_bit;
    logic         diff_valid;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int errors;
    int checks;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .diff_bit   (diff_bit),
        .diff_valid (diff_valid),
        .done       (done),
        .diff       (diff),
        .bout       (bout),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge inside RUN; returns at the DONE negedge (or on timeout).
    task automatic wait_done(output int n, output int nv, output logic [W-1:0] bits);
        n    = 0;
        nv   = 0;
        bits = '0;
        while (!done && n < 4 * int'(W)) begin
            if (diff_valid) begin
                if (nv < int'(W)) bits[nv] = diff_bit;
                nv++;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vbin);
        @(negedge clk);
        a     = va;
        b     = vb;
        bin   = vbin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        bin   = ~vbin;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int           n;
        int           nv;
        logic [W-1:0] bits;
        launch(v.a, v.b, v.bin);
        check($sformatf("v%0d_busy_run", idx), busy, 1);
        wait_done(n, nv, bits);
        check($sformatf("v%0d_done", idx), done, 1);
        check($sformatf("v%0d_latency", idx), n, W);
        check($sformatf("v%0d_nvalid", idx), nv, W);
        check($sformatf("v%0d_serial_bits", idx), bits, v.diff);
        check($sformatf("v%0d_diff", idx), diff, v.diff);
        check($sformatf("v%0d_bout", idx), bout, v.bout);
        check($sformatf("v%0d_ovf", idx), ovf, OVF_EN ? v.ovf : 1'b0);
        check($sformatf("v%0d_busy_done", idx), {busy, diff_valid}, 0);
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), done, 0);
        check($sformatf("v%0d_diff_held", idx), diff, v.diff);
        check($sformatf("v%0d_bout_held", idx), bout, v.bout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        int           nv;
        logic [W-1:0] bits;

        errors = 0;
        checks = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        bin    = 1'b0;

        //           a      b      bin   diff   bout  ovf
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {busy, done, diff_valid, diff_bit, bout, ovf}, 0);
        check("reset_diff", diff, 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // start during RUN cycle 3 must not disturb the operation in flight
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        a     = 8'hFF;
        b     = 8'h00;
        bin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nv, bits);
        check("ign_done", done, 1);
        check("ign_latency", n, 4);
        check("ign_diff", diff, 8'h1E);
        check("ign_bout", bout, 0);

        // back-to-back: start held in DONE goes straight to RUN
        launch(8'h00, 8'h01, 1'b0);
        wait_done(n, nv, bits);
        check("b2b_first_done", done, 1);
        check("b2b_first_diff", diff, 8'hFF);
        a     = 8'h10;
        b     = 8'h0F;
        bin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_idle_busy", busy, 1);
        check("b2b_cleared", {done, bout, diff}, 0);
        wait_done(n, nv, bits);
        check("b2b_latency", n, W);
        check("b2b_second_diff", diff, 8'h00);
        check("b2b_second_bout", bout, 0);
        @(negedge clk);

        // reset in RUN cycle 4 discards the partial result
        launch(8'h5A, 8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs", {busy, done, diff_valid, bout, ovf}, 0);
        check("rst_mid_diff", diff, 0);
        repeat (2) @(negedge clk);
        check("rst_stays_idle", {busy, done}, 0);
        run_vec(vecs[3], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
